// File: rtl/bsg_link_pkg.sv
// Shared types and helpers for the credit-based link sender.
package bsg_link_pkg;

  typedef enum logic [1:0] {
    eInit  = 2'd0,
    eRun   = 2'd1,
    eError = 2'd2
  } link_state_e;

  // Width of a counter that must hold the full credit count inclusively.
  function automatic int credit_width(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/bsg_link_credit_counter.sv
// Remote-credit counter: load to full, down by one per send, up by the
// token decimation step per returned token; flags and saturates overflow.
module bsg_link_credit_counter
  import bsg_link_pkg::*;
#(
  parameter int remote_credits_p       = 16,
  parameter int lg_credit_decimation_p = 2,
  localparam int cred_w_lp             = credit_width(remote_credits_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 load_i,
  input  logic                 up_i,
  input  logic                 down_i,
  output logic [cred_w_lp-1:0] credits_o,
  output logic                 overflow_o
);

  localparam logic [cred_w_lp:0] max_lp  = (cred_w_lp+1)'(remote_credits_p);
  localparam logic [cred_w_lp:0] step_lp = (cred_w_lp+1)'(1 << lg_credit_decimation_p);

  logic [cred_w_lp-1:0] credits_d, credits_q;
  logic [cred_w_lp:0]   sum;

  // One bit wider than the count so a token on a full counter is visible.
  always_comb begin
    sum = {1'b0, credits_q} - {{cred_w_lp{1'b0}}, down_i} + (up_i ? step_lp : '0);
  end

  always_comb begin
    credits_d  = credits_q;
    overflow_o = 1'b0;
    if (load_i) begin
      credits_d = max_lp[cred_w_lp-1:0];
    end else if (sum > max_lp) begin
      credits_d  = max_lp[cred_w_lp-1:0];
      overflow_o = 1'b1;
    end else begin
      credits_d = sum[cred_w_lp-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) credits_q <= '0;
    else            credits_q <= credits_d;
  end

  assign credits_o = credits_q;

endmodule

// File: rtl/bsg_link_credit_sender.sv
// Credit-flow link sender: registered 1-cycle word forwarding gated by
// remote credits. BSG_LINK_CREDIT_SENDER_OVERFLOW_CHECK_EN traps overflow.
module bsg_link_credit_sender
  import bsg_link_pkg::*;
#(
  parameter int width_p                = -1,
  parameter int remote_credits_p       = 16,
  parameter int lg_credit_decimation_p = 2,
  localparam int data_w_lp             = (width_p > 0) ? width_p : 1,
  localparam int cred_w_lp             = credit_width(remote_credits_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 v_i,
  input  logic [data_w_lp-1:0] data_i,
  output logic                 ready_and_o,
  output logic                 link_v_o,
  output logic [data_w_lp-1:0] link_data_o,
  input  logic                 link_token_i,
  output logic [cred_w_lp-1:0] credits_o,
  output logic                 error_o
);

  link_state_e state_d, state_q;

  logic                 accept;
  logic                 load;
  logic                 token_en;
  logic                 overflow;
  logic [cred_w_lp-1:0] credits;

  logic                 link_v_d, link_v_q;
  logic [data_w_lp-1:0] link_data_d, link_data_q;
  logic                 error_d, error_q;

  bsg_link_credit_counter #(
    .remote_credits_p       (remote_credits_p),
    .lg_credit_decimation_p (lg_credit_decimation_p)
  ) u_cnt (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .load_i     (load),
    .up_i       (token_en),
    .down_i     (accept),
    .credits_o  (credits),
    .overflow_o (overflow)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= eInit;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      eInit:  state_d = eRun;
`ifdef BSG_LINK_CREDIT_SENDER_OVERFLOW_CHECK_EN
      eRun:   if (overflow) state_d = eError;
`else
      eRun:   state_d = eRun;
`endif
      eError: state_d = eError;
      default: state_d = eInit;
    endcase
  end

  // Tokens count only in eRun: dropped during the load cycle, ignored once trapped.
  always_comb begin
    load        = (state_q == eInit);
    token_en    = link_token_i & (state_q == eRun);
    ready_and_o = (state_q == eRun) & (credits != '0);
  end

  assign accept = v_i & ready_and_o;

  always_comb begin
    link_v_d    = accept;
    link_data_d = accept ? data_i : link_data_q;
`ifdef BSG_LINK_CREDIT_SENDER_OVERFLOW_CHECK_EN
    error_d     = error_q | ((state_q == eRun) & overflow);
`else
    error_d     = 1'b0;
`endif
  end

`ifndef BSG_LINK_CREDIT_SENDER_OVERFLOW_CHECK_EN
  // Counter saturates on its own; the flag has no consumer here.
  logic unused_overflow;
  assign unused_overflow = overflow;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      link_v_q    <= 1'b0;
      link_data_q <= '0;
      error_q     <= 1'b0;
    end else begin
      link_v_q    <= link_v_d;
      link_data_q <= link_data_d;
      error_q     <= error_d;
    end
  end

  assign link_v_o    = link_v_q;
  assign link_data_o = link_data_q;
  assign credits_o   = credits;
  assign error_o     = error_q;

endmodule

// File: tb/tb_bsg_link_credit_sender.sv
// Directed vector bench for bsg_link_credit_sender (8 credits, 2 per token).
module tb_bsg_link_credit_sender;

`ifdef BSG_LINK_CREDIT_SENDER_OVERFLOW_CHECK_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        v;
  logic [15:0] d;
  logic        rdy;
  logic        lv;
  logic [15:0] ld;
  logic        tok;
  logic [3:0]  cr;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  bsg_link_credit_sender #(
    .width_p                (16),
    .remote_credits_p       (8),
    .lg_credit_decimation_p (1)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (rst_n),
    .v_i          (v),
    .data_i       (d),
    .ready_and_o  (rdy),
    .link_v_o     (lv),
    .link_data_o  (ld),
    .link_token_i (tok),
    .credits_o    (cr),
    .error_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        tok;
    logic        rdy;
    logic        lv;
    logic [15:0] ld;
    logic [3:0]  cr;
    logic        err;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(logic iv, logic [15:0] id, logic it, logic er,
                              logic elv, logic [15:0] eld, logic [3:0] ecr, logic eerr);
    vec_t r;
    r.v = iv; r.d = id; r.tok = it;
    r.rdy = er; r.lv = elv; r.ld = eld; r.cr = ecr; r.err = eerr;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    // Row i: inputs driven in cycle i, outputs expected during cycle i
    // (cycle 0 is the eInit cycle right after reset release).
    tbl[0]  = mk(1, 16'h0001, 0, 0, 0, 16'h0000, 0, 0);
    tbl[1]  = mk(1, 16'h0001, 0, 1, 0, 16'h0000, 8, 0);
    tbl[2]  = mk(1, 16'h0002, 0, 1, 1, 16'h0001, 7, 0);
    tbl[3]  = mk(1, 16'h0003, 0, 1, 1, 16'h0002, 6, 0);
    tbl[4]  = mk(1, 16'h0004, 0, 1, 1, 16'h0003, 5, 0);
    tbl[5]  = mk(1, 16'h0005, 0, 1, 1, 16'h0004, 4, 0);
    tbl[6]  = mk(1, 16'h0006, 0, 1, 1, 16'h0005, 3, 0);
    tbl[7]  = mk(1, 16'h0007, 0, 1, 1, 16'h0006, 2, 0);
    tbl[8]  = mk(1, 16'h0008, 0, 1, 1, 16'h0007, 1, 0);
    tbl[9]  = mk(1, 16'h0009, 0, 0, 1, 16'h0008, 0, 0);
    tbl[10] = mk(1, 16'h0009, 1, 0, 0, 16'h0008, 0, 0);
    tbl[11] = mk(1, 16'h000A, 0, 1, 0, 16'h0008, 2, 0);
    tbl[12] = mk(1, 16'h000B, 0, 1, 1, 16'h000A, 1, 0);
    tbl[13] = mk(1, 16'h000C, 0, 0, 1, 16'h000B, 0, 0);
    tbl[14] = mk(0, 16'h0000, 1, 0, 0, 16'h000B, 0, 0);
    tbl[15] = mk(0, 16'h0000, 1, 1, 0, 16'h000B, 2, 0);
    tbl[16] = mk(1, 16'h0010, 1, 1, 0, 16'h000B, 4, 0);
    tbl[17] = mk(0, 16'h0000, 1, 1, 1, 16'h0010, 5, 0);
    tbl[18] = mk(1, 16'h0011, 1, 1, 0, 16'h0010, 7, 0);
    tbl[19] = mk(0, 16'h0000, 1, 1, 1, 16'h0011, 8, 0);
    tbl[20] = OVF ? mk(1, 16'h0012, 0, 0, 0, 16'h0011, 8, 1)
                  : mk(1, 16'h0012, 0, 1, 0, 16'h0011, 8, 0);
    tbl[21] = OVF ? mk(1, 16'h0013, 1, 0, 0, 16'h0011, 8, 1)
                  : mk(1, 16'h0013, 1, 1, 1, 16'h0012, 7, 0);
    tbl[22] = OVF ? mk(0, 16'h0000, 0, 0, 0, 16'h0011, 8, 1)
                  : mk(0, 16'h0000, 0, 1, 1, 16'h0013, 8, 0);

    rst_n = 1'b0; v = 1'b1; d = 16'hFFFF; tok = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset rdy", rdy, 0);
    chk("reset link_v", lv, 0);
    chk("reset link_data", ld, 0);
    chk("reset credits", cr, 0);
    chk("reset error", err, 0);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      v = tbl[i].v; d = tbl[i].d; tok = tbl[i].tok;
      #1;
      chk($sformatf("v%0d rdy", i), rdy, tbl[i].rdy);
      chk($sformatf("v%0d link_v", i), lv, tbl[i].lv);
      chk($sformatf("v%0d link_data", i), ld, tbl[i].ld);
      chk($sformatf("v%0d credits", i), cr, tbl[i].cr);
      chk($sformatf("v%0d error", i), err, tbl[i].err);
    end

    // Token during the eInit cycle must be dropped.
    @(negedge clk);
    rst_n = 1'b0; v = 1'b0; tok = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; tok = 1'b1;
    #1;
    chk("init rdy", rdy, 0);
    @(negedge clk);
    tok = 1'b0; v = 1'b1; d = 16'h0055;
    #1;
    chk("init token credits", cr, 8);
    chk("init token error", err, 0);
    chk("init token rdy", rdy, 1);

    // Asynchronous reset in the middle of a transfer.
    @(posedge clk);
    #2;
    chk("mid link_v before", lv, 1);
    chk("mid link_data before", ld, 16'h0055);
    rst_n = 1'b0;
    #1;
    chk("async link_v", lv, 0);
    chk("async credits", cr, 0);
    chk("async link_data", ld, 0);
    chk("async rdy", rdy, 0);
    chk("async error", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
